// File: rtl/issue_ctrl.sv
// Single-entry issue controller: dispatches held instructions to the ALU or
// memory, waits on loads, and redirects fetch on branch mispredicts.
module issue_ctrl #(
    parameter int I_WIDTH = 17,
    parameter int A_WIDTH = 10
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [I_WIDTH-1:0] instruction_data_i,
    input  logic [A_WIDTH-1:0] instruction_addr_i,
    input  logic               instruction_valid_i,
    output logic               dequeue_o,
    output logic               restart_o,
    output logic [A_WIDTH-1:0] restart_addr_o,
    output logic               load_store_valid_o,
    output logic               store_en_o,
    output logic [A_WIDTH-1:0] load_store_addr_o,
    output logic [I_WIDTH-1:0] store_data_o,
    input  logic [I_WIDTH-1:0] load_data_i,
    input  logic               load_data_valid_i,
    input  logic [A_WIDTH-1:0] op_addr_i,
    input  logic [I_WIDTH-1:0] op_data_i,
    input  logic               br_taken_i,
    input  logic [A_WIDTH-1:0] br_target_i,
    output logic               issue_valid_o,
    output logic [I_WIDTH-1:0] issue_instr_o,
    output logic [A_WIDTH-1:0] issue_addr_o,
    input  logic               issue_ready_i,
    output logic               wb_valid_o,
    output logic [I_WIDTH-1:0] wb_data_o
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, FLUSH} state_t;

    state_t             state;
    logic [I_WIDTH-1:0] instr_r;
    logic [A_WIDTH-1:0] addr_r;
    logic [A_WIDTH-1:0] expect_r;
    logic               valid_r;

    logic [3:0]         opcode;
    logic               is_load;
    logic               is_store;
    logic               is_branch;
    logic               is_alu;
    logic               held;
    logic               retire;
    logic               mispredict;
    logic               flush_hit;
    logic [A_WIDTH-1:0] next_seq;

    assign issue_instr_o = instr_r;
    assign issue_addr_o  = addr_r;

    always_comb begin
        opcode    = instr_r[15:12];
        is_load   = (opcode == 4'hA);
        is_store  = (opcode == 4'hB);
        is_branch = (opcode == 4'hC);
        is_alu    = !(is_load || is_store || is_branch);
        next_seq  = addr_r + 1'b1;

        // Combinational outputs are gated by reset so nothing leaks out
        // while reset is held, regardless of stale hold-register contents.
        held       = reset_n && (state == RUN) && valid_r;
        mispredict = held && is_branch && (br_taken_i ^ instr_r[16]);
        retire     = held && (is_store || is_branch ||
                              (is_alu && issue_ready_i));
        flush_hit  = (state == FLUSH) && instruction_valid_i &&
                     (instruction_addr_i == expect_r);

        dequeue_o = 1'b0;
        if (reset_n) begin
            case (state)
                RUN:     dequeue_o = instruction_valid_i &&
                                     (!valid_r || retire) && !mispredict;
                FLUSH:   dequeue_o = instruction_valid_i;
                default: dequeue_o = 1'b0;
            endcase
        end

        issue_valid_o      = held && is_alu;
        load_store_valid_o = held && (is_load || is_store);
        store_en_o         = held && is_store;
        load_store_addr_o  = load_store_valid_o ? op_addr_i : '0;
        store_data_o       = store_en_o ? op_data_i : '0;

        restart_o      = mispredict;
        restart_addr_o = '0;
        if (mispredict)
            restart_addr_o = br_taken_i ? br_target_i : next_seq;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= RUN;
            valid_r    <= 1'b0;
            instr_r    <= '0;
            addr_r     <= '0;
            expect_r   <= '0;
            wb_valid_o <= 1'b0;
            wb_data_o  <= '0;
        end else begin
            wb_valid_o <= 1'b0;
            case (state)
                RUN: begin
                    if (mispredict) begin
                        state    <= FLUSH;
                        expect_r <= restart_addr_o;
                        valid_r  <= 1'b0;
                    end else if (held && is_load) begin
                        state <= MEM_WAIT;
                    end else if (dequeue_o) begin
                        instr_r <= instruction_data_i;
                        addr_r  <= instruction_addr_i;
                        valid_r <= 1'b1;
                    end else if (retire) begin
                        valid_r <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (load_data_valid_i) begin
                        wb_valid_o <= 1'b1;
                        wb_data_o  <= load_data_i;
                        valid_r    <= 1'b0;
                        state      <= RUN;
                    end
                end
                FLUSH: begin
                    if (flush_hit) begin
                        instr_r <= instruction_data_i;
                        addr_r  <= instruction_addr_i;
                        valid_r <= 1'b1;
                        state   <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_issue_ctrl.sv
// Scoreboard bench for issue_ctrl: directed fetch-queue traffic, with a
// negedge monitor popping expected issue/memory/writeback/restart events.
module tb_issue_ctrl;

    localparam int IW = 17;
    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [IW-1:0] instruction_data_i;
    logic [AW-1:0] instruction_addr_i;
    logic          instruction_valid_i;
    logic          dequeue_o;
    logic          restart_o;
    logic [AW-1:0] restart_addr_o;
    logic          load_store_valid_o;
    logic          store_en_o;
    logic [AW-1:0] load_store_addr_o;
    logic [IW-1:0] store_data_o;
    logic [IW-1:0] load_data_i;
    logic          load_data_valid_i;
    logic [AW-1:0] op_addr_i;
    logic [IW-1:0] op_data_i;
    logic          br_taken_i;
    logic [AW-1:0] br_target_i;
    logic          issue_valid_o;
    logic [IW-1:0] issue_instr_o;
    logic [AW-1:0] issue_addr_o;
    logic          issue_ready_i;
    logic          wb_valid_o;
    logic [IW-1:0] wb_data_o;

    issue_ctrl #(.I_WIDTH(IW), .A_WIDTH(AW)) dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .instruction_data_i (instruction_data_i),
        .instruction_addr_i (instruction_addr_i),
        .instruction_valid_i(instruction_valid_i),
        .dequeue_o          (dequeue_o),
        .restart_o          (restart_o),
        .restart_addr_o     (restart_addr_o),
        .load_store_valid_o (load_store_valid_o),
        .store_en_o         (store_en_o),
        .load_store_addr_o  (load_store_addr_o),
        .store_data_o       (store_data_o),
        .load_data_i        (load_data_i),
        .load_data_valid_i  (load_data_valid_i),
        .op_addr_i          (op_addr_i),
        .op_data_i          (op_data_i),
        .br_taken_i         (br_taken_i),
        .br_target_i        (br_target_i),
        .issue_valid_o      (issue_valid_o),
        .issue_instr_o      (issue_instr_o),
        .issue_addr_o       (issue_addr_o),
        .issue_ready_i      (issue_ready_i),
        .wb_valid_o         (wb_valid_o),
        .wb_data_o          (wb_data_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [AW+IW-1:0]   fq[$];
    logic [AW+IW-1:0]   exp_issue[$];
    logic [AW+IW:0]     exp_mem[$];
    logic [IW-1:0]      exp_wb[$];
    logic [AW-1:0]      exp_rst[$];

    logic          s_deq;
    logic          s_iv;
    logic [AW-1:0] s_iaddr;
    logic          s_lsv;
    logic          s_wb;
    logic          s_rst;

    function automatic void check(string name, logic [31:0] act,
                                  logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void unexpected(string name, logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: unexpected event value 0x%0h expected none",
                 name, act);
    endfunction

    // Monitor: every DUT output event is matched against the scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (issue_valid_o && issue_ready_i) begin
                if (exp_issue.size() == 0)
                    unexpected("issue", {5'd0, issue_addr_o, issue_instr_o});
                else
                    check("issue", {5'd0, issue_addr_o, issue_instr_o},
                          {5'd0, exp_issue.pop_front()});
            end
            if (load_store_valid_o) begin
                if (exp_mem.size() == 0) begin
                    unexpected("mem_req", {21'd0, store_en_o,
                                           load_store_addr_o});
                end else begin
                    logic [AW+IW:0] e;
                    e = exp_mem.pop_front();
                    check("mem_store_en", {31'd0, store_en_o},
                          {31'd0, e[AW+IW]});
                    check("mem_addr", {22'd0, load_store_addr_o},
                          {22'd0, e[AW+IW-1:IW]});
                    if (e[AW+IW])
                        check("mem_data", {15'd0, store_data_o},
                              {15'd0, e[IW-1:0]});
                end
            end
            if (wb_valid_o) begin
                if (exp_wb.size() == 0)
                    unexpected("wb", {15'd0, wb_data_o});
                else
                    check("wb_data", {15'd0, wb_data_o},
                          {15'd0, exp_wb.pop_front()});
            end
            if (restart_o) begin
                if (exp_rst.size() == 0)
                    unexpected("restart", {22'd0, restart_addr_o});
                else
                    check("restart_addr", {22'd0, restart_addr_o},
                          {22'd0, exp_rst.pop_front()});
            end else if (restart_addr_o != '0) begin
                unexpected("restart_addr_idle", {22'd0, restart_addr_o});
            end
        end
    end

    task automatic drive_head();
        if (fq.size() > 0) begin
            instruction_valid_i = 1'b1;
            instruction_addr_i  = fq[0][AW+IW-1:IW];
            instruction_data_i  = fq[0][IW-1:0];
        end else begin
            instruction_valid_i = 1'b0;
            instruction_addr_i  = '0;
            instruction_data_i  = '0;
        end
    endtask

    task automatic push(logic [AW-1:0] a, logic [IW-1:0] d);
        fq.push_back({a, d});
        drive_head();
    endtask

    task automatic step();
        @(negedge clk);
        s_deq   = dequeue_o;
        s_iv    = issue_valid_o;
        s_iaddr = issue_addr_o;
        s_lsv   = load_store_valid_o;
        s_wb    = wb_valid_o;
        s_rst   = restart_o;
        @(posedge clk);
        #1;
        if (s_deq && fq.size() > 0) void'(fq.pop_front());
        drive_head();
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n           = 1'b0;
        load_data_i       = '0;
        load_data_valid_i = 1'b0;
        op_addr_i         = '0;
        op_data_i         = '0;
        br_taken_i        = 1'b0;
        br_target_i       = '0;
        issue_ready_i     = 1'b1;
        drive_head();

        // Reset state
        step();
        step();
        check("rst_dequeue", {31'd0, s_deq}, 0);
        check("rst_issue_valid", {31'd0, s_iv}, 0);
        check("rst_ls_valid", {31'd0, s_lsv}, 0);
        check("rst_wb_valid", {31'd0, s_wb}, 0);
        check("rst_restart", {31'd0, s_rst}, 0);
        reset_n = 1'b1;
        idle(2);

        // ALU stream, ready high
        exp_issue.push_back({10'h000, 17'h00001});
        exp_issue.push_back({10'h001, 17'h00002});
        push(10'h000, 17'h00001);
        push(10'h001, 17'h00002);
        step(); check("alu_deq0", {31'd0, s_deq}, 1);
        step(); check("alu_deq1", {31'd0, s_deq}, 1);
        check("alu_iv1", {31'd0, s_iv}, 1);
        step(); check("alu_deq_empty", {31'd0, s_deq}, 0);
        check("alu_iv2", {31'd0, s_iv}, 1);
        idle(2);

        // Backpressure
        issue_ready_i = 1'b0;
        push(10'h002, 17'h00003);
        push(10'h003, 17'h00004);
        step(); check("bp_capture", {31'd0, s_deq}, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("bp_deq_stall", {31'd0, s_deq}, 0);
            check("bp_iv_hold", {31'd0, s_iv}, 1);
            check("bp_addr_hold", {22'd0, s_iaddr}, 32'h002);
        end
        exp_issue.push_back({10'h002, 17'h00003});
        exp_issue.push_back({10'h003, 17'h00004});
        issue_ready_i = 1'b1;
        step(); check("bp_release_deq", {31'd0, s_deq}, 1);
        idle(3);

        // Store
        op_addr_i = 10'h005;
        op_data_i = 17'h00055;
        exp_mem.push_back({1'b1, 10'h005, 17'h00055});
        push(10'h004, 17'h0B000);
        step();
        step(); check("st_iv", {31'd0, s_iv}, 0);
        check("st_lsv", {31'd0, s_lsv}, 1);
        step(); check("st_one_cycle", {31'd0, s_lsv}, 0);
        idle(1);

        // Load with 4-cycle latency and a queued follower
        op_addr_i = 10'h3F5;
        exp_mem.push_back({1'b1 ^ 1'b1, 10'h3F5, 17'h00000});
        push(10'h005, 17'h0A000);
        push(10'h006, 17'h00007);
        step(); check("ld_capture", {31'd0, s_deq}, 1);
        step(); check("ld_req_nodeq", {31'd0, s_deq}, 0);
        check("ld_req", {31'd0, s_lsv}, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            check("ld_wait_nodeq", {31'd0, s_deq}, 0);
            check("ld_wait_nolsv", {31'd0, s_lsv}, 0);
        end
        load_data_i       = 17'h1ABCD;
        load_data_valid_i = 1'b1;
        exp_wb.push_back(17'h1ABCD);
        exp_issue.push_back({10'h006, 17'h00007});
        step(); check("ld_resp_nodeq", {31'd0, s_deq}, 0);
        load_data_valid_i = 1'b0;
        load_data_i       = '0;
        step(); check("ld_wb", {31'd0, s_wb}, 1);
        check("ld_next_deq", {31'd0, s_deq}, 1);
        step(); check("ld_wb_pulse", {31'd0, s_wb}, 0);
        idle(1);

        // Stray load response in RUN is ignored
        load_data_i       = 17'h01111;
        load_data_valid_i = 1'b1;
        step();
        load_data_valid_i = 1'b0;
        step(); check("stray_wb", {31'd0, s_wb}, 0);

        // Mispredict: predicted taken, not taken, wrap to 0
        br_taken_i = 1'b0;
        exp_rst.push_back(10'h000);
        exp_issue.push_back({10'h000, 17'h00020});
        push(10'h3FF, 17'h1C000);
        push(10'h010, 17'h00010);
        push(10'h011, 17'h00011);
        push(10'h000, 17'h00020);
        step(); check("mp_capture", {31'd0, s_deq}, 1);
        step(); check("mp_restart", {31'd0, s_rst}, 1);
        check("mp_nodeq", {31'd0, s_deq}, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("fl_deq", {31'd0, s_deq}, 1);
            check("fl_iv", {31'd0, s_iv}, 0);
            check("fl_restart", {31'd0, s_rst}, 0);
        end
        step(); check("fl_resume_iv", {31'd0, s_iv}, 1);
        idle(1);

        // Mispredict taken, then a correctly predicted taken branch
        br_taken_i  = 1'b1;
        br_target_i = 10'h123;
        exp_rst.push_back(10'h123);
        exp_issue.push_back({10'h123, 17'h00030});
        exp_issue.push_back({10'h125, 17'h00031});
        push(10'h009, 17'h0C000);
        push(10'h00A, 17'h00099);
        push(10'h123, 17'h00030);
        push(10'h124, 17'h1C000);
        push(10'h125, 17'h00031);
        idle(9);
        br_taken_i = 1'b0;

        // Reset during MEM_WAIT abandons the load
        op_addr_i = 10'h100;
        exp_mem.push_back({1'b0, 10'h100, 17'h00000});
        push(10'h020, 17'h0A000);
        step();
        step(); check("rl_req", {31'd0, s_lsv}, 1);
        step();
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        load_data_i       = 17'h02222;
        load_data_valid_i = 1'b1;
        exp_issue.push_back({10'h021, 17'h00040});
        push(10'h021, 17'h00040);
        step(); check("rl_wb0", {31'd0, s_wb}, 0);
        check("rl_run_deq", {31'd0, s_deq}, 1);
        step(); check("rl_wb1", {31'd0, s_wb}, 0);
        load_data_valid_i = 1'b0;
        idle(3);

        check("left_issue", exp_issue.size(), 0);
        check("left_mem", exp_mem.size(), 0);
        check("left_wb", exp_wb.size(), 0);
        check("left_restart", exp_rst.size(), 0);
        check("left_fetch", fq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_ctrl.md
ISSUE_CTRL -- requirements
Module: issue_ctrl

Interface
REQ-001 SHALL have parameter I_WIDTH, default 17: instruction and data word width.
REQ-002 SHALL have parameter A_WIDTH, default 10: instruction/data address width.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1: synchronous, active-low reset.
REQ-005 SHALL have ports instruction_data_i / instruction_addr_i / instruction_valid_i  input  I_WIDTH / A_WIDTH / 1: head of the fetch queue.
REQ-006 SHALL have port dequeue_o  output  1: pops the fetch-queue head in the same cycle.
REQ-007 SHALL have ports restart_o / restart_addr_o  output  1 / A_WIDTH: redirect request to fetch.
REQ-008 SHALL have ports load_store_valid_o / store_en_o / load_store_addr_o / store_data_o  output  1 / 1 / A_WIDTH / I_WIDTH: memory request.
REQ-009 SHALL have ports load_data_i / load_data_valid_i  input  I_WIDTH / 1: load response.
REQ-010 SHALL have ports op_addr_i / op_data_i  input  A_WIDTH / I_WIDTH: effective address and store data for the held instruction, from the datapath.
REQ-011 SHALL have ports br_taken_i / br_target_i  input  1 / A_WIDTH: branch resolution for the held instruction.
REQ-012 SHALL have ports issue_valid_o / issue_instr_o / issue_addr_o  output  1 / I_WIDTH / A_WIDTH and issue_ready_i  input  1: ALU issue handshake.
REQ-013 SHALL have ports wb_valid_o / wb_data_o  output  1 / I_WIDTH: load writeback.

Function
REQ-014 SHALL keep a one-entry hold register (instr_r, addr_r, valid_r); issue_instr_o=instr_r, issue_addr_o=addr_r.
REQ-015 SHALL classify by opcode instr_r[15:12]: 4'hA LOAD, 4'hB STORE, 4'hC BRANCH, all others ALU; instr_r[16] is the fetch prediction bit (1 = predicted taken).
REQ-016 SHALL implement states RUN, MEM_WAIT, FLUSH.
REQ-017 In RUN, dequeue_o = instruction_valid_i AND (NOT valid_r OR held instruction retires this cycle) AND NOT mispredict this cycle; on dequeue, capture head into hold register next edge with valid_r=1.
REQ-018 ALU: issue_valid_o=valid_r in RUN; retires in the cycle issue_valid_o AND issue_ready_i.
REQ-019 STORE: in RUN with valid_r, drive load_store_valid_o=1, store_en_o=1, load_store_addr_o=op_addr_i, store_data_o=op_data_i for exactly one cycle; retires that cycle; issue_valid_o=0.
REQ-020 LOAD: in RUN with valid_r, drive load_store_valid_o=1, store_en_o=0, load_store_addr_o=op_addr_i for one cycle, then MEM_WAIT; no retire, no dequeue.
REQ-021 MEM_WAIT: memory outputs 0, dequeue_o=0; on load_data_valid_i, register load_data_i into wb_data_o, pulse wb_valid_o=1 next cycle, retire, return to RUN.
REQ-022 load_data_valid_i outside MEM_WAIT SHALL be ignored.
REQ-023 BRANCH: retires in one RUN cycle; mispredict = br_taken_i XOR instr_r[16].
REQ-024 On mispredict: restart_o=1 for that cycle only, restart_addr_o = br_taken_i ? br_target_i : addr_r+1 (A_WIDTH wrap, max -> 0); store that address as expect_r; enter FLUSH.
REQ-025 FLUSH: restart_o=0, issue and memory outputs 0; dequeue_o=instruction_valid_i; heads with instruction_addr_i != expect_r are discarded; first head with address == expect_r is captured into hold register and state returns to RUN.
REQ-026 restart_addr_o SHALL be 0 whenever restart_o=0.
REQ-027 Correctly predicted branches SHALL NOT assert restart_o.

Reset
REQ-028 While reset_n=0 at a clock edge: state RUN, valid_r=0, expect_r=0, wb_valid_o=0, wb_data_o=0; all request/issue outputs 0.
REQ-029 Reset SHALL override every state including MEM_WAIT (pending load abandoned; a later load_data_valid_i is ignored) and FLUSH.

Verification
REQ-030 ALU stream: heads 0x00001@0,0x00002@1, issue_ready_i=1 -> dequeue every cycle, issue_valid_o one cycle each, issue_addr_o 0 then 1.
REQ-031 Backpressure: ALU held, issue_ready_i=0 for 3 cycles -> issue_valid_o held, dequeue_o=0 for 3 cycles, no instruction lost.
REQ-032 Load: instr 0x0A000, op_addr_i=0x3F5, response after 4 cycles with 0x1ABCD -> one request cycle, store_en_o=0, no dequeue while waiting, wb_valid_o one cycle, wb_data_o=0x1ABCD.
REQ-033 Mispredict: BRANCH at addr 0x3FF, instr[16]=1, br_taken_i=0 -> restart_o one cycle, restart_addr_o=0x000; stale heads @0x010,0x011 dequeued and discarded, head @0x000 captured.
REQ-034 Store: instr 0x0B000, op_addr_i=0x005, op_data_i=0x00055 -> single cycle load_store_valid_o=1, store_en_o=1, addr 0x005, data 0x00055.
REQ-035 Reset in MEM_WAIT, then load_data_valid_i=1 -> wb_valid_o stays 0, state RUN, valid_r=0.
